// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-outstanding command to Wishbone classic master with retry and timeout
//
// Purpose:
//   Accepts one command at a time on a valid/ready handshake and runs it as a
//   Wishbone classic cycle. The cycle ends on err_i, ack_i or rty_i, with err_i
//   taking priority over ack_i, and ack_i over rty_i. A cycle also ends when the
//   per-attempt timeout expires. Each rty_i causes a one-cycle gap with the bus
//   idle, then a re-issue, up to MAX_RETRY times. The result is presented on a
//   valid/ready response handshake.
//
// Ports:
//   clk_i, rst_i           clock; asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake; ready only while idle
//   cmd_we/adr/sel/dat     command fields, latched on acceptance
//   rsp_valid/rsp_ready    response handshake
//   rsp_dat                read data (0 for writes and failed reads)
//   rsp_status             00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT
//   cyc_o/stb_o/we_o       Wishbone master control
//   adr_o/sel_o/dat_o      Wishbone master address, lanes, write data
//   dat_i/ack_i/err_i/rty_i Wishbone slave response

module wb_cmd_master #(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_we,
    input  logic [ADR_WIDTH-1:0]   cmd_adr,
    input  logic [DAT_WIDTH/8-1:0] cmd_sel,
    input  logic [DAT_WIDTH-1:0]   cmd_dat,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DAT_WIDTH-1:0]   rsp_dat,
    output logic [1:0]             rsp_status,

    output logic                   cyc_o,
    output logic                   stb_o,
    output logic                   we_o,
    output logic [ADR_WIDTH-1:0]   adr_o,
    output logic [DAT_WIDTH/8-1:0] sel_o,
    output logic [DAT_WIDTH-1:0]   dat_o,
    input  logic [DAT_WIDTH-1:0]   dat_i,
    input  logic                   ack_i,
    input  logic                   err_i,
    input  logic                   rty_i
);

    localparam int SEL_WIDTH = DAT_WIDTH / 8;
    localparam int RTY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    // The counter holds the number of BUS cycles already spent in this attempt,
    // so the attempt ends on the cycle where it still reads TIMEOUT-1.
    localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_RTY_EXH = 2'b10;
    localparam logic [1:0] ST_TMO     = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        BACKOFF = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                 state, state_nx;
    logic                   we_nx;
    logic [ADR_WIDTH-1:0]   adr_nx;
    logic [SEL_WIDTH-1:0]   sel_nx;
    logic [DAT_WIDTH-1:0]   dat_nx;
    logic [DAT_WIDTH-1:0]   rdat_nx;
    logic [1:0]             status_nx;
    logic [RTY_W-1:0]       rty_cnt, rty_nx;
    logic [15:0]            tmo_cnt, tmo_nx;

    // Handshake and bus strobes are decoded from the state register only, so
    // no slave input reaches an output without passing through a flop, and an
    // asynchronous reset drops cyc_o/stb_o immediately.
    assign cmd_ready = (state == IDLE);
    assign cyc_o     = (state == BUS);
    assign stb_o     = (state == BUS);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            we_o       <= 1'b0;
            adr_o      <= '0;
            sel_o      <= '0;
            dat_o      <= '0;
            rsp_dat    <= '0;
            rsp_status <= ST_OK;
            rty_cnt    <= '0;
            tmo_cnt    <= '0;
        end else begin
            state      <= state_nx;
            we_o       <= we_nx;
            adr_o      <= adr_nx;
            sel_o      <= sel_nx;
            dat_o      <= dat_nx;
            rsp_dat    <= rdat_nx;
            rsp_status <= status_nx;
            rty_cnt    <= rty_nx;
            tmo_cnt    <= tmo_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        we_nx     = we_o;
        adr_nx    = adr_o;
        sel_nx    = sel_o;
        dat_nx    = dat_o;
        rdat_nx   = rsp_dat;
        status_nx = rsp_status;
        rty_nx    = rty_cnt;
        tmo_nx    = tmo_cnt;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    we_nx     = cmd_we;
                    adr_nx    = cmd_adr;
                    sel_nx    = cmd_sel;
                    dat_nx    = cmd_dat;
                    // Start from a zero payload so writes and failed reads
                    // report 0 without further work.
                    rdat_nx   = '0;
                    status_nx = ST_OK;
                    rty_nx    = '0;
                    tmo_nx    = '0;
                    state_nx  = BUS;
                end
            end

            BUS: begin
                if (err_i) begin
                    status_nx = ST_ERR;
                    state_nx  = RESP;
                end else if (ack_i) begin
                    status_nx = ST_OK;
                    if (!we_o) begin
                        rdat_nx = dat_i;
                    end
                    state_nx  = RESP;
                end else if (rty_i) begin
                    if (rty_cnt == RTY_MAX) begin
                        status_nx = ST_RTY_EXH;
                        state_nx  = RESP;
                    end else begin
                        rty_nx   = rty_cnt + RTY_W'(1);
                        state_nx = BACKOFF;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    status_nx = ST_TMO;
                    state_nx  = RESP;
                end else begin
                    tmo_nx = tmo_cnt + 16'd1;
                end
            end

            BACKOFF: begin
                tmo_nx   = '0;
                state_nx = BUS;
            end

            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - directed self-checking bench for wb_cmd_master

module tb_wb_cmd_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o, dat_i;
    logic [3:0]  sel_o;
    logic        ack_i, err_i, rty_i;

    int n_cmp = 0;
    int n_err = 0;

    wb_cmd_master #(
        .ADR_WIDTH(32),
        .DAT_WIDTH(32),
        .MAX_RETRY(3),
        .TIMEOUT  (4)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_sel   (cmd_sel),
        .cmd_dat   (cmd_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_status(rsp_status),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .we_o      (we_o),
        .adr_o     (adr_o),
        .sel_o     (sel_o),
        .dat_o     (dat_o),
        .dat_i     (dat_i),
        .ack_i     (ack_i),
        .err_i     (err_i),
        .rty_i     (rty_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a command for one edge; on return the DUT is in its first BUS cycle.
    task automatic issue(input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat);
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_sel   = sel;
        cmd_dat   = dat;
        cmd_valid = 1'b1;
        chk("issue_ready", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        chk("issue_cyc", 64'(cyc_o), 64'd1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("consume_valid", 64'(rsp_valid), 64'd0);
        chk("consume_ready", 64'(cmd_ready), 64'd1);
    endtask

    // One rty_i followed by the one-cycle gap; returns in the next BUS cycle.
    task automatic retry_once(input int idx);
        rty_i = 1'b1;
        tick();
        rty_i = 1'b0;
        chk($sformatf("backoff_gap%0d", idx), 64'(cyc_o), 64'd0);
        tick();
        chk($sformatf("reissue%0d", idx), 64'(cyc_o), 64'd1);
    endtask

    initial begin
        int cyc_count;

        rst_i     = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_sel   = '0;
        cmd_dat   = '0;
        rsp_ready = 1'b0;
        dat_i     = '0;
        ack_i     = 1'b0;
        err_i     = 1'b0;
        rty_i     = 1'b0;

        tick();
        tick();
        chk("rst_cyc",       64'(cyc_o),      64'd0);
        chk("rst_stb",       64'(stb_o),      64'd0);
        chk("rst_we",        64'(we_o),       64'd0);
        chk("rst_adr",       64'(adr_o),      64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid),  64'd0);
        chk("rst_status",    64'(rsp_status), 64'd0);
        chk("rst_rsp_dat",   64'(rsp_dat),    64'd0);
        chk("rst_ready",     64'(cmd_ready),  64'd1);
        rst_i = 1'b0;
        tick();

        // Read acked on the second BUS cycle: cyc_o high exactly 2 cycles.
        issue(1'b0, 32'h10, 4'hF, 32'h0);
        chk("rd_adr",   64'(adr_o),     64'h10);
        chk("rd_we",    64'(we_o),      64'd0);
        chk("rd_cmdrdy",64'(cmd_ready), 64'd0);
        tick();
        chk("rd_cyc2",  64'(cyc_o),     64'd1);
        ack_i = 1'b1;
        dat_i = 32'hA5A5_A5A5;
        tick();
        ack_i = 1'b0;
        dat_i = 32'h0;
        chk("rd_cyc_off", 64'(cyc_o),      64'd0);
        chk("rd_valid",   64'(rsp_valid),  64'd1);
        chk("rd_dat",     64'(rsp_dat),    64'hA5A5_A5A5);
        chk("rd_status",  64'(rsp_status), 64'd0);
        consume();

        // Write: bus data ignored, response data 0.
        issue(1'b1, 32'h20, 4'hF, 32'h1234_5678);
        chk("wr_dat_o", 64'(dat_o), 64'h1234_5678);
        chk("wr_sel_o", 64'(sel_o), 64'hF);
        chk("wr_we_o",  64'(we_o),  64'd1);
        chk("wr_adr_o", 64'(adr_o), 64'h20);
        ack_i = 1'b1;
        dat_i = 32'hDEAD_BEEF;
        tick();
        ack_i = 1'b0;
        dat_i = 32'h0;
        chk("wr_valid",  64'(rsp_valid),  64'd1);
        chk("wr_status", 64'(rsp_status), 64'd0);
        chk("wr_rspdat", 64'(rsp_dat),    64'd0);
        consume();

        // Three retries then ack: still OK.
        issue(1'b0, 32'h30, 4'h3, 32'h0);
        for (int i = 0; i < 3; i++) retry_once(i);
        chk("rty_adr_hold", 64'(adr_o), 64'h30);
        ack_i = 1'b1;
        dat_i = 32'h0000_005A;
        tick();
        ack_i = 1'b0;
        dat_i = 32'h0;
        chk("rty_ok_valid",  64'(rsp_valid),  64'd1);
        chk("rty_ok_status", 64'(rsp_status), 64'd0);
        chk("rty_ok_dat",    64'(rsp_dat),    64'h5A);
        consume();

        // Four retries: exhausted.
        issue(1'b0, 32'h40, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) retry_once(i + 3);
        rty_i = 1'b1;
        tick();
        rty_i = 1'b0;
        chk("exh_cyc",    64'(cyc_o),      64'd0);
        chk("exh_valid",  64'(rsp_valid),  64'd1);
        chk("exh_status", 64'(rsp_status), 64'd2);
        chk("exh_dat",    64'(rsp_dat),    64'd0);
        consume();

        // Timeout with TIMEOUT=4: cyc_o high exactly 4 cycles.
        issue(1'b0, 32'h50, 4'hF, 32'h0);
        cyc_count = 0;
        while (cyc_o && cyc_count < 20) begin
            cyc_count++;
            tick();
        end
        chk("tmo_cycles", 64'(cyc_count),  64'd4);
        chk("tmo_cyc",    64'(cyc_o),      64'd0);
        chk("tmo_valid",  64'(rsp_valid),  64'd1);
        chk("tmo_status", 64'(rsp_status), 64'd3);
        consume();

        // err_i and ack_i together: ERR wins; response held while not ready.
        issue(1'b0, 32'h60, 4'hF, 32'h0);
        err_i = 1'b1;
        ack_i = 1'b1;
        dat_i = 32'h1111_1111;
        tick();
        err_i = 1'b0;
        ack_i = 1'b0;
        dat_i = 32'h0;
        chk("sim_status", 64'(rsp_status), 64'd1);
        chk("sim_dat",    64'(rsp_dat),    64'd0);
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ack_i = (i == 2);
            tick();
            chk($sformatf("hold_valid%0d", i),  64'(rsp_valid),  64'd1);
            chk($sformatf("hold_status%0d", i), 64'(rsp_status), 64'd1);
            chk($sformatf("hold_dat%0d", i),    64'(rsp_dat),    64'd0);
            chk($sformatf("hold_cmdrdy%0d", i), 64'(cmd_ready),  64'd0);
            chk($sformatf("hold_cyc%0d", i),    64'(cyc_o),      64'd0);
        end
        ack_i     = 1'b0;
        cmd_valid = 1'b0;
        consume();

        // Reset pulse during BUS: cyc_o drops before the next edge, no response.
        issue(1'b1, 32'h70, 4'hF, 32'hCAFE_F00D);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_cyc", 64'(cyc_o), 64'd0);
        chk("arst_stb", 64'(stb_o), 64'd0);
        tick();
        rst_i = 1'b0;
        tick();
        chk("arst_valid", 64'(rsp_valid), 64'd0);
        chk("arst_ready", 64'(cmd_ready), 64'd1);
        chk("arst_adr",   64'(adr_o),     64'd0);
        tick();
        chk("arst_valid2", 64'(rsp_valid), 64'd0);
        chk("arst_cyc2",   64'(cyc_o),     64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
